instr_mem_seq: RTL
==================

Name: instr_mem_seq

Overview:
Parametrised instruction memory with a streaming load port and a sequential/branching fetch port.
- After reset it accepts a program as a valid/ready word stream, then serves fetches from an internal program counter (PC) or from an explicit jump address.
- It replaces file-driven loading with a handshake any loader (UART, testbench, boot ROM) can drive.
- It sits between the program loader and the GPP fetch/decode stage.

Parameters:
DATA_W, 16, instruction word width in bits
DEPTH, 400, number of instruction words stored
ADDR_W, 9, address/PC width; must satisfy 2^ADDR_W >= DEPTH
CNT_W, 9, load counter width; must satisfy 2^CNT_W > DEPTH

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
reload  in  1  single-cycle pulse; discard program and return to load phase
load_valid  in  1  load word present
load_data  in  DATA_W  instruction word to store
load_last  in  1  marks final word of program (qualified by load_valid)
load_ready  out  1  block can accept a load word
load_done  out  1  program loaded, fetch enabled
load_count  out  CNT_W  number of words loaded
fetch_req  in  1  fetch request (one per cycle max)
fetch_jump  in  1  use fetch_addr instead of PC (branch)
fetch_addr  in  ADDR_W  jump target address
fetch_valid  out  1  single-cycle pulse, response present
fetch_data  out  DATA_W  fetched instruction
fetch_pc  out  ADDR_W  address the response came from
fetch_fault  out  1  request address >= load_count; fetch_data forced to 0

Behaviour:
- States: S_LOAD, S_RUN. Reset enters S_LOAD.
- Reset values: load_done=0, load_count=0, PC=0, fetch_valid=0, fetch_data=0, fetch_pc=0, fetch_fault=0. load_ready is combinational: 1 in S_LOAD, else 0. Memory array is not reset.
- S_LOAD: a load is accepted when load_valid && load_ready. On acceptance, mem[load_count]<=load_data and load_count<=load_count+1.
- Leave S_LOAD for S_RUN on the same edge as an accepted word with load_last=1, or when the accepted word fills slot DEPTH-1. The DEPTH-1 case is an implicit last; later words are refused.
- load_done is 1 exactly while in S_RUN, so it rises the cycle after the final accepted word.
- In S_LOAD, fetch_req is ignored and fetch_valid stays 0.
- In S_RUN, load_valid is ignored and load_count is held.
- S_RUN fetch, when fetch_req=1: A = fetch_jump ? fetch_addr : PC. Response arrives on the next edge (1-cycle latency):
  - If A < load_count: fetch_valid=1, fetch_data=mem[A], fetch_pc=A, fetch_fault=0, PC<=A+1 (modulo 2^ADDR_W).
  - Otherwise: fetch_valid=1, fetch_fault=1, fetch_data=0, fetch_pc=A, PC unchanged.
- Back-to-back requests are sustained at 1 per cycle. fetch_valid returns to 0 in any cycle following a cycle with no request.
- Sequential fetch past the last word faults repeatedly until a jump is issued.
- reload has priority over load and fetch in the same cycle. Next state S_LOAD; load_count=0, PC=0, load_done=0, fetch_valid=0, fetch_fault=0. Memory contents are retained but unreachable until reloaded.
- An asynchronous rst mid-load or mid-fetch gives the same result as power-up reset. Partially loaded data is discarded logically.
- Zero-length program is impossible: the first accepted word is always counted, so load_last on the first word gives load_count=1.

Decomposition:
- Package instr_mem_pkg: state enum (S_LOAD, S_RUN), default DATA_W/DEPTH/ADDR_W constants.
- Sub-module instr_ram: DEPTH x DATA_W, one synchronous write port, one synchronous read port (1-cycle read). Fault masking and all control stay in instr_mem_seq.

Test Plan:
- Load 4 words 0x1001,0x1002,0x1003,0x1004 (last on 4th) -> load_ready drops after 4th, load_count=4, load_done=1 next cycle.
- 5 sequential fetch_req, no jump -> fetch_data 0x1001..0x1004 with fetch_pc 0..3, then 5th fetch_fault=1, fetch_data=0, fetch_pc=4.
- Jump fetch_addr=2 then 2 sequential -> 0x1003 (pc 2), 0x1004 (pc 3), fault (pc 4); jump to 7 -> fault, PC stays 4.
- Stream DEPTH words without load_last -> transition to S_RUN after word DEPTH-1, load_count=400; extra load_valid sees load_ready=0 and memory is unchanged.
- reload asserted same cycle as fetch_req -> no fetch_valid next cycle, load_done=0, load_count=0; new 2-word load then fetch returns the new words.
- rst low mid-load after 2 words -> all outputs at reset values immediately (asynchronous); load restarts at address 0.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared types and default sizing for the instruction memory with streaming load
// and PC/jump fetch.
package instr_mem_pkg;

  typedef enum logic {
    S_LOAD,
    S_RUN
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 400;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_CNT_W  = 9;

endpackage

// File: rtl/instr_mem_seq_if.sv
// Load stream and fetch port bundle between a program loader / fetch stage (master)
// and the instruction memory (slave).
interface instr_mem_seq_if
  import instr_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) ();

  logic              reload;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic [CNT_W-1:0]  load_count;
  logic              fetch_req;
  logic              fetch_jump;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic [ADDR_W-1:0] fetch_pc;
  logic              fetch_fault;

  modport master (
    output reload, load_valid, load_data, load_last,
    output fetch_req, fetch_jump, fetch_addr,
    input  load_ready, load_done, load_count,
    input  fetch_valid, fetch_data, fetch_pc, fetch_fault
  );

  modport slave (
    input  reload, load_valid, load_data, load_last,
    input  fetch_req, fetch_jump, fetch_addr,
    output load_ready, load_done, load_count,
    output fetch_valid, fetch_data, fetch_pc, fetch_fault
  );

endinterface

// File: rtl/instr_ram.sv
// Simple dual-port instruction storage: one synchronous write, one synchronous read
// with a single cycle of latency. Contents are never reset.
module instr_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 400,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_seq.sv
// Instruction memory: accepts a program as a valid/ready word stream, then serves
// sequential or jump fetches with one cycle of latency and out-of-range fault flagging.
module instr_mem_seq
  import instr_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  instr_mem_seq_if.slave bus
);

  localparam int CMP_W = (ADDR_W > CNT_W) ? ADDR_W : CNT_W;

  state_t            r_state;
  logic [CNT_W-1:0]  r_loadCount;
  logic [ADDR_W-1:0] r_pc;
  logic              r_fetchValid;
  logic              r_fetchFault;
  logic              r_fetchHit;
  logic [ADDR_W-1:0] r_fetchPc;

  logic              w_loadAccept;
  logic              w_lastWord;
  logic              w_fetchGo;
  logic [ADDR_W-1:0] w_fetchAddr;
  logic              w_fetchHit;
  logic [DATA_W-1:0] w_ramData;

  // reload wins over any load or fetch presented in the same cycle
  assign w_loadAccept = bus.load_valid && (r_state == S_LOAD) && !bus.reload;
  assign w_lastWord   = bus.load_last || (r_loadCount == CNT_W'(DEPTH - 1));
  assign w_fetchGo    = bus.fetch_req && (r_state == S_RUN) && !bus.reload;
  assign w_fetchAddr  = bus.fetch_jump ? bus.fetch_addr : r_pc;
  assign w_fetchHit   = CMP_W'(w_fetchAddr) < CMP_W'(r_loadCount);

  instr_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_loadAccept),
    .i_waddr (ADDR_W'(r_loadCount)),
    .i_wdata (bus.load_data),
    .i_re    (w_fetchGo && w_fetchHit),
    .i_raddr (w_fetchAddr),
    .o_rdata (w_ramData)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_LOAD;
      r_loadCount  <= '0;
      r_pc         <= '0;
      r_fetchValid <= 1'b0;
      r_fetchFault <= 1'b0;
      r_fetchHit   <= 1'b0;
      r_fetchPc    <= '0;
    end else if (bus.reload) begin
      r_state      <= S_LOAD;
      r_loadCount  <= '0;
      r_pc         <= '0;
      r_fetchValid <= 1'b0;
      r_fetchFault <= 1'b0;
      r_fetchHit   <= 1'b0;
    end else begin
      r_fetchValid <= w_fetchGo;
      if (r_state == S_LOAD) begin
        if (w_loadAccept) begin
          r_loadCount <= r_loadCount + CNT_W'(1);
          if (w_lastWord) begin
            r_state <= S_RUN;
          end
        end
      end else if (w_fetchGo) begin
        r_fetchPc    <= w_fetchAddr;
        r_fetchFault <= !w_fetchHit;
        r_fetchHit   <= w_fetchHit;
        if (w_fetchHit) begin
          r_pc <= w_fetchAddr + ADDR_W'(1);
        end
      end
    end
  end

  // Data is masked to zero on faults and until the first successful fetch
  assign bus.fetch_data  = r_fetchHit ? w_ramData : '0;
  assign bus.load_ready  = (r_state == S_LOAD);
  assign bus.load_done   = (r_state == S_RUN);
  assign bus.load_count  = r_loadCount;
  assign bus.fetch_valid = r_fetchValid;
  assign bus.fetch_pc    = r_fetchPc;
  assign bus.fetch_fault = r_fetchFault;

endmodule
